// File: rtl/dsm_pkg.sv
// Shared types and constants for the delta-sigma DAC sample scheduler.
//   sample_t     : 16-bit signed audio sample / modulator input word
//   state_t      : scheduler sequencing states
//   DSM_FULL_POS : most positive modulator input
//   DSM_FULL_NEG : most negative modulator input
package dsm_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam sample_t DSM_FULL_POS = 16'h7FFF;
  localparam sample_t DSM_FULL_NEG = 16'h8000;

endpackage

// File: rtl/dsm_fifo.sv
// Synchronous sample FIFO with a flush input.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : advance the head (ignored when empty)
//   flush_i    : empty the FIFO on this edge; wins over push and pop
//   wdata_i    : sample to write
//   rdata_o    : head sample (valid while !empty_o)
//   full_o, empty_o, level_o : occupancy status, registered
module dsm_fifo
  import dsm_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  sample_t       wdata_i,
  output sample_t       rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  sample_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     level_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dsm_dac_sched.sv
// Sample scheduler and rate controller in front of a second-order
// delta-sigma DAC modulator. Buffers input samples, generates the modulator
// clock-enable and holds each sample on din for osr+1 cke ticks.
//   clk, rst      : clock, synchronous active-high reset
//   enable        : run request; low returns to IDLE and flushes the FIFO
//   clk_div, osr  : cke period (clk_div+1 clks) and ticks per sample (osr+1),
//                   sampled only while IDLE
//   s_valid/s_ready/s_data : sample input stream
//   cke, dsm_rst, din      : modulator clock-enable, reset and input word
//   underrun      : one-cycle pulse for each sample slot found the FIFO empty
//   fifo_level    : FIFO occupancy
//   running       : high in RUN
//   dbg_state_o   : current sequencing state
//
// Stream handshake: a sample transfers on every rising clk edge where
// s_valid && s_ready. s_ready depends only on state and FIFO fullness, never
// on s_valid. A transfer in the cycle enable drops is accepted and then
// discarded by the flush.
module dsm_dac_sched
  import dsm_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  parameter  int DIV_W      = 16,
  parameter  int PRIME_LVL  = 4,
  parameter  int CLR_CYC    = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1,
  localparam int CW         = $clog2(CLR_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [7:0]       osr,
  input  logic             s_valid,
  output logic             s_ready,
  input  sample_t          s_data,
  output logic             cke,
  output logic             dsm_rst,
  output sample_t          din,
  output logic             underrun,
  output logic [LW-1:0]    fifo_level,
  output logic             running,
  output state_t           dbg_state_o
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_sh_q;
  logic [7:0]       osr_sh_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [7:0]       tick_cnt_q;
  logic [CW-1:0]    clr_cnt_q;
  logic             cke_q;
  sample_t          din_q;
  logic             underrun_q;

  logic             active;
  logic             abort;
  logic             slot_end;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  sample_t          fifo_rdata;

  assign active     = (state_q == PRIME) || (state_q == RUN);
  assign abort      = (state_q != IDLE) && !enable;
  // Slot boundary: last tick of the current sample hold.
  assign slot_end   = (state_q == RUN) && enable && cke_q && (tick_cnt_q == osr_sh_q);
  assign fifo_pop   = slot_end && !fifo_empty;
  assign fifo_flush = (state_q == IDLE) || abort;
  assign s_ready    = active && !fifo_full;
  assign fifo_push  = s_valid && s_ready;

  assign cke         = cke_q;
  assign dsm_rst     = (state_q == IDLE) || (state_q == CLEAR);
  assign din         = din_q;
  assign underrun    = underrun_q;
  assign running     = (state_q == RUN);
  assign dbg_state_o = state_q;

  dsm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (s_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = CLEAR;
      CLEAR:   if (clr_cnt_q == CW'(CLR_CYC - 1)) state_d = PRIME;
      PRIME:   if (fifo_level >= LW'(PRIME_LVL)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_sh_q   <= '0;
      osr_sh_q   <= '0;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      clr_cnt_q  <= '0;
      cke_q      <= 1'b0;
      din_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      underrun_q <= slot_end && fifo_empty;

      if (state_q == IDLE) begin
        div_sh_q <= clk_div;
        osr_sh_q <= osr;
      end

      clr_cnt_q <= (state_q == CLEAR) ? clr_cnt_q + CW'(1) : '0;

      // Prescaler only runs in PRIME/RUN, so it restarts from zero after CLEAR.
      if (active && !abort) begin
        div_cnt_q <= (div_cnt_q == div_sh_q) ? '0 : div_cnt_q + DIV_W'(1);
        cke_q     <= (div_cnt_q == div_sh_q);
      end else begin
        div_cnt_q <= '0;
        cke_q     <= 1'b0;
      end

      // Held at zero outside RUN so the first slot starts fresh on RUN entry.
      if ((state_q == RUN) && enable) begin
        if (cke_q) tick_cnt_q <= slot_end ? 8'd0 : tick_cnt_q + 8'd1;
      end else begin
        tick_cnt_q <= 8'd0;
      end

      // On an empty slot din keeps its previous value.
      if (fifo_flush) din_q <= '0;
      else if (fifo_pop) din_q <= fifo_rdata;
    end
  end

endmodule

// File: tb/tb_dsm_dac_sched.sv
module tb_dsm_dac_sched;
  import dsm_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] clk_div;
  logic [7:0]  osr;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        cke;
  logic        dsm_rst;
  logic [15:0] din_w;
  logic        underrun;
  logic [3:0]  fifo_level;
  logic        running;
  state_t      dbg_state;

  always #5 clk = ~clk;

  dsm_dac_sched dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clk_div    (clk_div),
    .osr        (osr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cke        (cke),
    .dsm_rst    (dsm_rst),
    .din        (din_w),
    .underrun   (underrun),
    .fifo_level (fifo_level),
    .running    (running),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Inputs change only just after a rising edge; cycle() returns at the
  // following falling edge where outputs are sampled.
  logic        nxt_rst = 1'b1;
  logic        nxt_enable = 1'b0;
  logic [15:0] nxt_clk_div = 16'd3;
  logic [7:0]  nxt_osr = 8'd1;
  int          mode = 0;      // 0 none, 1 random, 2 sequence numbers, 3 directed list
  int          last_mode = 0;
  logic        acc = 1'b0;
  logic        prev_cke = 1'b0;
  logic [15:0] seq = 16'd0;
  logic [15:0] dir_q[$];

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 7))
      0:       return DSM_FULL_POS;
      1:       return DSM_FULL_NEG;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cycle();
    prev_cke = cke;
    @(posedge clk);
    #1;
    rst     = nxt_rst;
    enable  = nxt_enable;
    clk_div = nxt_clk_div;
    osr     = nxt_osr;
    if (mode != last_mode) acc = 1'b0;
    last_mode = mode;
    case (mode)
      1: if (acc || !s_valid) begin
           s_valid = ($urandom_range(0, 3) != 0);
           s_data  = rnd_sample();
         end
      2: begin
           if (acc) seq = seq + 16'd1;
           s_valid = 1'b1;
           s_data  = seq;
         end
      3: begin
           if (acc && dir_q.size() > 0) void'(dir_q.pop_front());
           s_valid = (dir_q.size() > 0);
           s_data  = s_valid ? dir_q[0] : 16'd0;
         end
      default: s_valid = 1'b0;
    endcase
    @(negedge clk);
    acc = s_valid && s_ready;
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected FIFO contents are the accepted samples in order; everything else
  // follows from cycle counts since the last state change.
  logic        mon_on = 1'b1;
  logic [15:0] exp_q[$];
  state_t      m_ph = IDLE;
  int          m_clr = 0;
  int          m_k = 0;        // clk cycles since PRIME entry
  int          m_ticks = 0;    // cke pulses counted in the current slot
  int          m_div = 0;
  int          m_osr = 0;
  logic [15:0] m_din = 16'd0;
  logic        m_und = 1'b0;
  logic        e_cke, e_rdy, hs;

  always @(negedge clk) begin
    if (mon_on) begin
      e_cke = (m_ph == PRIME || m_ph == RUN) && (m_k > 0) && ((m_k % (m_div + 1)) == 0);
      e_rdy = (m_ph == PRIME || m_ph == RUN) && (exp_q.size() < 8);
      chk("state",      32'(dbg_state),  32'(m_ph));
      chk("dsm_rst",    32'(dsm_rst),    32'(m_ph == IDLE || m_ph == CLEAR));
      chk("running",    32'(running),    32'(m_ph == RUN));
      chk("s_ready",    32'(s_ready),    32'(e_rdy));
      chk("cke",        32'(cke),        32'(e_cke));
      chk("din",        32'(din_w),      32'(m_din));
      chk("underrun",   32'(underrun),   32'(m_und));
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));

      hs    = s_valid && e_rdy;
      m_und = 1'b0;
      if (rst) begin
        m_ph = IDLE; exp_q.delete(); m_din = 16'd0; m_clr = 0; m_k = 0; m_ticks = 0;
      end else if (m_ph != IDLE && !enable) begin
        exp_q.delete(); m_din = 16'd0; m_ph = IDLE;
      end else begin
        case (m_ph)
          IDLE: begin
            m_div = int'(clk_div); m_osr = int'(osr); m_din = 16'd0;
            if (enable) begin m_ph = CLEAR; m_clr = 0; end
          end
          CLEAR: begin
            m_clr++;
            if (m_clr == 4) begin m_ph = PRIME; m_k = 0; end
          end
          PRIME: begin
            if (exp_q.size() >= 4) begin m_ph = RUN; m_ticks = 0; end
            if (hs) exp_q.push_back(s_data);
            m_k++;
          end
          default: begin
            if (e_cke) begin
              if (m_ticks == m_osr) begin
                if (exp_q.size() > 0) m_din = exp_q.pop_front();
                else m_und = 1'b1;
                m_ticks = 0;
              end else begin
                m_ticks++;
              end
            end
            if (hs) exp_q.push_back(s_data);
            m_k++;
          end
        endcase
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cke_period(output int p);
    int c;
    p = -1;
    for (int i = 0; i < 64 && !cke; i++) cycle();
    c = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      c++;
      if (cke) begin p = c; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, p;
    logic [15:0] vals[4];
    logic [15:0] last;
    vals[0] = 16'd200; vals[1] = 16'd300; vals[2] = 16'd400; vals[3] = 16'd500;
    rst = 1'b1; enable = 1'b0; clk_div = 16'd3; osr = 8'd1; s_valid = 1'b0; s_data = 16'd0;

    // Reset state
    cycle();
    cycle();
    chk("rst_dsm_rst",  32'(dsm_rst),    32'd1);
    chk("rst_s_ready",  32'(s_ready),    32'd0);
    chk("rst_cke",      32'(cke),        32'd0);
    chk("rst_din",      32'(din_w),      32'd0);
    chk("rst_underrun", 32'(underrun),   32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_running",  32'(running),    32'd0);
    chk("rst_state",    32'(dbg_state),  32'(IDLE));
    nxt_rst = 1'b0;
    cycle();

    // Start: clk_div=3, osr=1, five directed samples, then starve
    dir_q = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
    mode = 3;
    nxt_enable = 1'b1;
    for (int i = 0; i < 10 && dbg_state != CLEAR; i++) cycle();
    n = 0;
    for (int i = 0; i < 20 && dbg_state == CLEAR; i++) begin n++; cycle(); end
    chk("clear_len", 32'(n), 32'd4);
    for (int i = 0; i < 200 && din_w == 16'd0; i++) cycle();
    chk("din_first",     32'(din_w),    32'd100);
    chk("din_after_cke", 32'(prev_cke), 32'd1);
    for (int v = 0; v < 4; v++) begin
      last = din_w;
      for (int i = 0; i < 100 && din_w == last; i++) cycle();
      chk("din_seq", 32'(din_w), 32'(vals[v]));
    end
    for (int i = 0; i < 100 && !underrun; i++) cycle();
    chk("und_seen",    32'(underrun), 32'd1);
    chk("und_din",     32'(din_w),    32'd500);
    chk("und_running", 32'(running),  32'd1);
    n = 0;
    for (int i = 0; i < 64; i++) begin cycle(); n++; if (underrun) break; end
    chk("und_gap", 32'(n), 32'd8);
    cke_period(p);
    chk("cke_period_4", 32'(p), 32'd4);

    // Shadowing: new clk_div ignored in RUN
    nxt_clk_div = 16'd9;
    repeat (3) cycle();
    cke_period(p);
    chk("shadow_period", 32'(p), 32'd4);

    // Abort mid-slot with samples queued
    for (int i = 0; i < 3; i++) dir_q.push_back(rnd_sample());
    for (int i = 0; i < 50 && (dir_q.size() > 0 || s_valid); i++) cycle();
    nxt_enable = 1'b0;
    cycle();
    cycle();
    chk("abort_state",   32'(dbg_state),  32'(IDLE));
    chk("abort_din",     32'(din_w),      32'd0);
    chk("abort_level",   32'(fifo_level), 32'd0);
    chk("abort_dsm_rst", 32'(dsm_rst),    32'd1);
    chk("abort_s_ready", 32'(s_ready),    32'd0);
    repeat (2) cycle();

    // Restart picks up clk_div=9
    mode = 1;
    nxt_enable = 1'b1;
    for (int i = 0; i < 200 && !running; i++) cycle();
    chk("restart_running", 32'(running), 32'd1);
    cke_period(p);
    chk("cke_period_10", 32'(p), 32'd10);

    // Backpressure: clk_div=0, osr=7, valid always high with sequence numbers
    nxt_enable = 1'b0;
    repeat (3) cycle();
    nxt_clk_div = 16'd0;
    nxt_osr = 8'd7;
    mode = 2;
    cycle();
    nxt_enable = 1'b1;
    for (int i = 0; i < 100 && fifo_level != 4'd8; i++) cycle();
    chk("bp_full_level", 32'(fifo_level), 32'd8);
    chk("bp_full_ready", 32'(s_ready),    32'd0);
    n = 0;
    for (int i = 0; i < 160; i++) begin cycle(); if (acc) n++; end
    chk("bp_accepts", 32'(n), 32'd20);

    // Randomized rounds, including the clk_div=0/osr=0 corner
    for (int r = 0; r < 4; r++) begin
      nxt_enable = 1'b0;
      repeat (3) cycle();
      nxt_clk_div = (r == 0) ? 16'd0 : 16'($urandom_range(0, 3));
      nxt_osr     = (r == 0) ? 8'd0  : 8'($urandom_range(0, 3));
      mode = 1;
      cycle();
      nxt_enable = 1'b1;
      for (int i = 0; i < 250; i++) begin
        if (i == 120) begin
          nxt_clk_div = 16'($urandom_range(0, 15));
          nxt_osr     = 8'($urandom_range(0, 15));
        end
        cycle();
      end
    end
    nxt_enable = 1'b0;
    mode = 0;
    repeat (3) cycle();

    mon_on = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
